// File: rtl/z80_stack_seq.sv
// z80_stack_seq: 16-bit PUSH/POP over a byte memory port in two handshaked beats; done 3 cycles after accept plus mem_ack waits.
// req_ready only in IDLE, each beat stalls on mem_ack (optional WAIT_LIMIT timeout); Z80FI_STACK_TRACE_EN adds the trace port.
module z80_stack_seq #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_push,
  input  logic [15:0] req_data,
  input  logic [15:0] sp_in,
  output logic        done,
  output logic        err,
  output logic [15:0] pop_data,
  output logic [15:0] sp_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
`ifdef Z80FI_STACK_TRACE_EN
  ,
  output logic        trace_valid,
  output logic        trace_push,
  output logic [15:0] trace_addr1,
  output logic [15:0] trace_addr2,
  output logic [15:0] trace_data
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [16:0] LIMIT = 17'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic        push_q, push_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] wait_q, wait_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] pop_data_q, pop_data_d;
  logic [15:0] sp_out_q, sp_out_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

`ifdef Z80FI_STACK_TRACE_EN
  logic        trace_valid_q, trace_valid_d;
  logic        trace_push_q, trace_push_d;
  logic [15:0] trace_addr1_q, trace_addr1_d;
  logic [15:0] trace_addr2_q, trace_addr2_d;
  logic [15:0] trace_data_q, trace_data_d;
`endif

  logic        in_beat;
  logic        beat_ack;
  logic        beat_timeout;
  logic [16:0] wait_next;

  assign in_beat   = (state_q == BEAT1) || (state_q == BEAT2);
  assign beat_ack  = in_beat && mem_req_q && mem_ack;
  assign wait_next = {1'b0, wait_q} + 17'd1;
  // An ack on the same edge wins over the timeout.
  assign beat_timeout = in_beat && !mem_ack && (LIMIT != 17'd0) && (wait_next == LIMIT);

  always_comb begin
    state_d     = state_q;
    push_d      = push_q;
    sp_d        = sp_q;
    data_d      = data_q;
    lo_d        = lo_q;
    wait_d      = wait_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pop_data_d  = pop_data_q;
    sp_out_d    = sp_out_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef Z80FI_STACK_TRACE_EN
    trace_valid_d = 1'b0;
    trace_push_d  = trace_push_q;
    trace_addr1_d = trace_addr1_q;
    trace_addr2_d = trace_addr2_q;
    trace_data_d  = trace_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = BEAT1;
          push_d      = req_push;
          sp_d        = sp_in;
          data_d      = req_data;
          wait_d      = 16'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = req_push;
          mem_addr_d  = req_push ? (sp_in - 16'd1) : sp_in;
          mem_wdata_d = req_push ? req_data[15:8] : 8'h00;
        end
      end

      BEAT1: begin
        if (beat_ack) begin
          state_d     = BEAT2;
          lo_d        = mem_rdata;
          wait_d      = 16'd0;
          mem_addr_d  = push_q ? (sp_q - 16'd2) : (sp_q + 16'd1);
          mem_wdata_d = push_q ? data_q[7:0] : 8'h00;
        end else if (beat_timeout) begin
          state_d   = FIN;
          err_d     = 1'b1;
          sp_out_d  = sp_q;
          wait_d    = 16'd0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          wait_d = wait_next[15:0];
        end
      end

      BEAT2: begin
        if (beat_ack) begin
          state_d   = FIN;
          done_d    = 1'b1;
          wait_d    = 16'd0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          sp_out_d  = push_q ? (sp_q - 16'd2) : (sp_q + 16'd2);
          if (!push_q) begin
            pop_data_d = {mem_rdata, lo_q};
          end
`ifdef Z80FI_STACK_TRACE_EN
          trace_valid_d = 1'b1;
          trace_push_d  = push_q;
          trace_addr1_d = push_q ? (sp_q - 16'd1) : sp_q;
          trace_addr2_d = push_q ? (sp_q - 16'd2) : (sp_q + 16'd1);
          trace_data_d  = push_q ? data_q : {mem_rdata, lo_q};
`endif
        end else if (beat_timeout) begin
          // The BEAT1 byte in lo_q is simply never used.
          state_d   = FIN;
          err_d     = 1'b1;
          sp_out_d  = sp_q;
          wait_d    = 16'd0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          wait_d = wait_next[15:0];
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      push_q      <= 1'b0;
      sp_q        <= 16'h0000;
      data_q      <= 16'h0000;
      lo_q        <= 8'h00;
      wait_q      <= 16'h0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pop_data_q  <= 16'h0000;
      sp_out_q    <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      sp_q        <= sp_d;
      data_q      <= data_d;
      lo_q        <= lo_d;
      wait_q      <= wait_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pop_data_q  <= pop_data_d;
      sp_out_q    <= sp_out_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef Z80FI_STACK_TRACE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid_q <= 1'b0;
      trace_push_q  <= 1'b0;
      trace_addr1_q <= 16'h0000;
      trace_addr2_q <= 16'h0000;
      trace_data_q  <= 16'h0000;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_push_q  <= trace_push_d;
      trace_addr1_q <= trace_addr1_d;
      trace_addr2_q <= trace_addr2_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_push  = trace_push_q;
  assign trace_addr1 = trace_addr1_q;
  assign trace_addr2 = trace_addr2_q;
  assign trace_data  = trace_data_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign pop_data  = pop_data_q;
  assign sp_out    = sp_out_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_z80_stack_seq.sv
// Directed bench for z80_stack_seq: POP/PUSH, address wrap, wait states, timeout, async reset, back-to-back.
module tb_z80_stack_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_push = 1'b0;
  logic [15:0] req_data = 16'h0000;
  logic [15:0] sp_in = 16'h0000;
  logic        done;
  logic        err;
  logic [15:0] pop_data;
  logic [15:0] sp_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
`ifdef Z80FI_STACK_TRACE_EN
  logic        trace_valid;
  logic        trace_push;
  logic [15:0] trace_addr1;
  logic [15:0] trace_addr2;
  logic [15:0] trace_data;
`endif

  logic [7:0] mem [0:65535];
  int errors = 0;
  int checks = 0;

  z80_stack_seq #(.WAIT_LIMIT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_push  (req_push),
    .req_data  (req_data),
    .sp_in     (sp_in),
    .done      (done),
    .err       (err),
    .pop_data  (pop_data),
    .sp_out    (sp_out),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef Z80FI_STACK_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_push  (trace_push),
    .trace_addr1 (trace_addr1),
    .trace_addr2 (trace_addr2),
    .trace_data  (trace_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts on the next edge; afterwards the bench sits in cycle 1.
  task automatic start_req(input logic push, input logic [15:0] data, input logic [15:0] sp);
    req_valid = 1'b1;
    req_push  = push;
    req_data  = data;
    sp_in     = sp;
    tick;
    req_valid = 1'b0;
    req_push  = ~push;
    req_data  = 16'h0000;
    sp_in     = 16'h5555;
  endtask

  // Memory responder for one beat: waits, then acks; reports what the bus held.
  task automatic serve_beat(input int waits, output logic [15:0] addr, output logic we,
                            output logic stable);
    addr   = mem_addr;
    we     = mem_we;
    stable = mem_req;
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      tick;
      if (mem_addr !== addr || mem_req !== 1'b1 || mem_we !== we) stable = 1'b0;
    end
    mem_ack   = 1'b1;
    mem_rdata = mem[mem_addr];
    if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
    tick;
    mem_ack   = 1'b0;
    mem_rdata = 8'h5A;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++;
    if ({mem_req, mem_we, done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {mem_req, mem_we, done, err});
    end
    checks++;
    if ({pop_data, sp_out, mem_addr, mem_wdata} !== 56'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {pop_data, sp_out, mem_addr, mem_wdata});
    end
    tick;
    reset_n = 1'b1;
    tick;
    checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got ready=%b req=%b expected 1/0", req_ready, mem_req);
    end
  endtask

  task automatic test_pop_basic;
    logic [15:0] a1, a2;
    logic w1, w2, s1, s2;
    mem[16'h1234] = 8'hCD;
    mem[16'h1235] = 8'hAB;
    start_req(1'b0, 16'h0000, 16'h1234);
    checks++;
    if (req_ready !== 1'b0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL pop_c1: got ready=%b req=%b expected 0/1", req_ready, mem_req);
    end
    serve_beat(0, a1, w1, s1);
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL pop_c2: got done=%b req=%b expected 0/1", done, mem_req);
    end
    serve_beat(0, a2, w2, s2);
    checks++;
    if (a1 !== 16'h1234 || a2 !== 16'h1235) begin
      errors++; $display("FAIL pop_addr: got %h,%h expected 1234,1235", a1, a2);
    end
    checks++;
    if (w1 !== 1'b0 || w2 !== 1'b0) begin errors++; $display("FAIL pop_we: got %b%b expected 00", w1, w2); end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL pop_done: got done=%b err=%b req=%b expected 1/0/0", done, err, mem_req);
    end
    checks++;
    if (pop_data !== 16'hABCD) begin errors++; $display("FAIL pop_data: got %h expected ABCD", pop_data); end
    checks++;
    if (sp_out !== 16'h1236) begin errors++; $display("FAIL pop_sp: got %h expected 1236", sp_out); end
    tick;
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL pop_c4: got done=%b ready=%b expected 0/1", done, req_ready);
    end
  endtask

  task automatic test_push_wrap;
    logic [15:0] a1, a2;
    logic w1, w2, s1, s2;
    mem[16'hFFFF] = 8'h00;
    mem[16'hFFFE] = 8'h00;
    start_req(1'b1, 16'hBEEF, 16'h0000);
    serve_beat(0, a1, w1, s1);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL push_c2: got done=%b expected 0", done); end
    serve_beat(0, a2, w2, s2);
    checks++;
    if (a1 !== 16'hFFFF || a2 !== 16'hFFFE) begin
      errors++; $display("FAIL push_addr: got %h,%h expected FFFF,FFFE", a1, a2);
    end
    checks++;
    if (w1 !== 1'b1 || w2 !== 1'b1) begin errors++; $display("FAIL push_we: got %b%b expected 11", w1, w2); end
    checks++;
    if (mem[16'hFFFF] !== 8'hBE || mem[16'hFFFE] !== 8'hEF) begin
      errors++; $display("FAIL push_bytes: got %h,%h expected BE,EF", mem[16'hFFFF], mem[16'hFFFE]);
    end
    checks++;
    if (done !== 1'b1 || sp_out !== 16'hFFFE) begin
      errors++; $display("FAIL push_done: got done=%b sp=%h expected 1/FFFE", done, sp_out);
    end
    checks++;
    if (pop_data !== 16'hABCD) begin errors++; $display("FAIL push_popkeep: got %h expected ABCD", pop_data); end
    tick;

    start_req(1'b1, 16'h1357, 16'h0001);
    serve_beat(0, a1, w1, s1);
    serve_beat(0, a2, w2, s2);
    checks++;
    if (a1 !== 16'h0000 || a2 !== 16'hFFFF) begin
      errors++; $display("FAIL push1_addr: got %h,%h expected 0000,FFFF", a1, a2);
    end
    checks++;
    if (mem[16'h0000] !== 8'h13 || mem[16'hFFFF] !== 8'h57) begin
      errors++; $display("FAIL push1_bytes: got %h,%h expected 13,57", mem[16'h0000], mem[16'hFFFF]);
    end
    checks++;
    if (done !== 1'b1 || sp_out !== 16'hFFFF) begin
      errors++; $display("FAIL push1_done: got done=%b sp=%h expected 1/FFFF", done, sp_out);
    end
    tick;
  endtask

  task automatic test_pop_wait;
    logic [15:0] a1, a2;
    logic w1, w2, s1, s2;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    start_req(1'b0, 16'h0000, 16'hFFFF);
    serve_beat(3, a1, w1, s1);
    serve_beat(3, a2, w2, s2);
    checks++;
    if (a1 !== 16'hFFFF || a2 !== 16'h0000) begin
      errors++; $display("FAIL wait_addr: got %h,%h expected FFFF,0000", a1, a2);
    end
    checks++;
    if (s1 !== 1'b1 || s2 !== 1'b1) begin errors++; $display("FAIL wait_stable: got %b%b expected 11", s1, s2); end
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL wait_done_c9: got done=%b err=%b expected 1/0", done, err);
    end
    checks++;
    if (pop_data !== 16'h2211 || sp_out !== 16'h0001) begin
      errors++; $display("FAIL wait_result: got data=%h sp=%h expected 2211/0001", pop_data, sp_out);
    end
    tick;
  endtask

  task automatic test_timeout;
    start_req(1'b1, 16'h1357, 16'h4000);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (mem_req !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL tmo_c%0d: got req=%b err=%b expected 1/0", k, mem_req, err);
      end
      tick;
    end
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL tmo_err: got err=%b done=%b req=%b expected 1/0/0", err, done, mem_req);
    end
    checks++;
    if (sp_out !== 16'h4000 || pop_data !== 16'h2211) begin
      errors++; $display("FAIL tmo_result: got sp=%h data=%h expected 4000/2211", sp_out, pop_data);
    end
    tick;
    checks++;
    if (req_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL tmo_after: got ready=%b err=%b done=%b expected 1/0/0", req_ready, err, done);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] a1, a2;
    logic w1, w2, s1, s2;
    mem[16'h2000] = 8'h44;
    mem[16'h2001] = 8'h33;
    start_req(1'b0, 16'h0000, 16'h2000);
    serve_beat(0, a1, w1, s1);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h2001) begin
      errors++; $display("FAIL rst_beat2: got req=%b addr=%h expected 1/2001", mem_req, mem_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async: got req=%b ready=%b expected 0/1", mem_req, req_ready);
    end
    checks++;
    if ({done, err, mem_we, pop_data, sp_out, mem_addr, mem_wdata} !== 59'h0) begin
      errors++; $display("FAIL rst_outputs: got %h expected 0", {done, err, mem_we, pop_data, sp_out, mem_addr, mem_wdata});
    end
    tick;
    tick;
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_nopulse: got done=%b err=%b expected 0/0", done, err);
    end
    reset_n = 1'b1;
    tick;
    start_req(1'b0, 16'h0000, 16'h2000);
    serve_beat(0, a1, w1, s1);
    serve_beat(0, a2, w2, s2);
    checks++;
    if (done !== 1'b1 || pop_data !== 16'h3344 || sp_out !== 16'h2002) begin
      errors++; $display("FAIL rst_redo: got done=%b data=%h sp=%h expected 1/3344/2002", done, pop_data, sp_out);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a1, a2;
    logic w1, w2, s1, s2;
    mem[16'h3000] = 8'h66;
    mem[16'h3001] = 8'h55;
    mem[16'h3100] = 8'h88;
    mem[16'h3101] = 8'h77;
    req_valid = 1'b1;
    req_push  = 1'b0;
    sp_in     = 16'h3000;
    tick;
    sp_in = 16'h3100;
    checks++;
    if (req_ready !== 1'b0 || mem_addr !== 16'h3000) begin
      errors++; $display("FAIL b2b_c1: got ready=%b addr=%h expected 0/3000", req_ready, mem_addr);
    end
    serve_beat(0, a1, w1, s1);
    serve_beat(0, a2, w2, s2);
    checks++;
    if (done !== 1'b1 || pop_data !== 16'h5566 || sp_out !== 16'h3002) begin
      errors++; $display("FAIL b2b_first: got done=%b data=%h sp=%h expected 1/5566/3002", done, pop_data, sp_out);
    end
    tick;
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_c4: got ready=%b done=%b req=%b expected 1/0/0", req_ready, done, mem_req);
    end
    tick;
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h3100 || pop_data !== 16'h5566) begin
      errors++; $display("FAIL b2b_c5: got req=%b addr=%h data=%h expected 1/3100/5566", mem_req, mem_addr, pop_data);
    end
    serve_beat(0, a1, w1, s1);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_c6: got done=%b expected 0", done); end
    serve_beat(0, a2, w2, s2);
    checks++;
    if (done !== 1'b1 || pop_data !== 16'h7788 || sp_out !== 16'h3102 || a2 !== 16'h3101) begin
      errors++; $display("FAIL b2b_second: got done=%b data=%h sp=%h a2=%h expected 1/7788/3102/3101",
                         done, pop_data, sp_out, a2);
    end
    tick;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset;
    test_pop_basic;
    test_push_wrap;
    test_pop_wait;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
